// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI write-channel arbiter.
package axi_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } wr_state_e;

endpackage

// File: rtl/wr_grant_arb.sv
// Two-way grant decision for the AXI write arbiter.
// Build option AXI_WR_RR_EN: round-robin on ties (the master that did not
// own the last transaction wins); otherwise M0 always wins ties.
module wr_grant_arb (
  input  logic req0_i,
  input  logic req1_i,
`ifdef AXI_WR_RR_EN
  input  logic rr_last_i,
`endif
  output logic gnt1_o
);

`ifdef AXI_WR_RR_EN
  // M1 wins when alone, or on a tie when M0 owned the previous transaction
  always_comb begin
    gnt1_o = req1_i && (!req0_i || !rr_last_i);
  end
`else
  // M1 wins only when M0 is not requesting
  always_comb begin
    gnt1_o = req1_i && !req0_i;
  end
`endif

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI write port (AW/W/B) between M0 (dcache write-back) and
// M1 (uncached store buffer). One master owns AW, W and B from grant to its
// B handshake; W beat count is checked against AWLEN (sticky wr_err).
// Build option AXI_WR_RR_EN selects round-robin arbitration instead of
// fixed M0 priority.
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [7:0]          m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic [1:0]          m0_awburst,
  input  logic [1:0]          m0_awlock,
  input  logic [3:0]          m0_awcache,
  input  logic [2:0]          m0_awprot,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ID_W-1:0]     m0_wid,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wlast,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [ID_W-1:0]     m0_bid,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  // master 1
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic [1:0]          m1_awlock,
  input  logic [3:0]          m1_awcache,
  input  logic [2:0]          m1_awprot,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ID_W-1:0]     m1_wid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [ID_W-1:0]     m1_bid,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // slave side
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  // status
  output logic                wr_busy,
  output logic                wr_err
);

  localparam logic [AXI_LEN_W:0] BEAT_ONE = 1;

  wr_state_e              state_q;
  logic                   own_q;
  logic [AXI_LEN_W:0]     beat_cnt_q;
  logic [AXI_LEN_W-1:0]   len_q;
  logic                   wr_err_q;
  logic                   gnt1;
`ifdef AXI_WR_RR_EN
  logic                   rr_last_q;
`endif

  wr_grant_arb u_grant (
    .req0_i    (m0_awvalid),
    .req1_i    (m1_awvalid),
`ifdef AXI_WR_RR_EN
    .rr_last_i (rr_last_q),
`endif
    .gnt1_o    (gnt1)
  );

  // Payload muxes follow the owner in every state; only the valids gate them
  always_comb begin
    awid    = own_q ? m1_awid    : m0_awid;
    awaddr  = own_q ? m1_awaddr  : m0_awaddr;
    awlen   = own_q ? m1_awlen   : m0_awlen;
    awsize  = own_q ? m1_awsize  : m0_awsize;
    awburst = own_q ? m1_awburst : m0_awburst;
    awlock  = own_q ? m1_awlock  : m0_awlock;
    awcache = own_q ? m1_awcache : m0_awcache;
    awprot  = own_q ? m1_awprot  : m0_awprot;
    wid     = own_q ? m1_wid     : m0_wid;
    wdata   = own_q ? m1_wdata   : m0_wdata;
    wstrb   = own_q ? m1_wstrb   : m0_wstrb;
    wlast   = own_q ? m1_wlast   : m0_wlast;
    m0_bid   = bid;
    m0_bresp = bresp;
    m1_bid   = bid;
    m1_bresp = bresp;
  end

  // Handshake routing: only the owner's channel for the current phase is open
  always_comb begin
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    unique case (state_q)
      ADDR: begin
        awvalid    = own_q ? m1_awvalid : m0_awvalid;
        m0_awready = !own_q && awready;
        m1_awready = own_q && awready;
      end
      DATA: begin
        wvalid    = own_q ? m1_wvalid : m0_wvalid;
        m0_wready = !own_q && wready;
        m1_wready = own_q && wready;
      end
      RESP: begin
        bready    = own_q ? m1_bready : m0_bready;
        m0_bvalid = !own_q && bvalid;
        m1_bvalid = own_q && bvalid;
      end
      default: ;
    endcase
  end

  // Transaction FSM: arbitrate, address, data beats with length check, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      own_q      <= 1'b0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      wr_err_q   <= 1'b0;
`ifdef AXI_WR_RR_EN
      rr_last_q  <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0_awvalid || m1_awvalid) begin
            own_q   <= gnt1;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (awvalid && awready) begin
            len_q      <= awlen;
            beat_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (wvalid && wready) begin
            beat_cnt_q <= beat_cnt_q + BEAT_ONE;
            // beat_cnt_q is the index of the beat being accepted now
            if (wlast) begin
              if (beat_cnt_q != {1'b0, len_q}) wr_err_q <= 1'b1;
              state_q <= RESP;
            end else if (beat_cnt_q == {1'b0, len_q}) begin
              wr_err_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if (bvalid && bready) begin
            state_q <= IDLE;
`ifdef AXI_WR_RR_EN
            rr_last_q <= own_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_busy = (state_q != IDLE);
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: two bus-functional masters and
// a slave driven from one directed sequence with randomized timing/payload;
// expected owner order, bus payloads, beat counts and error flag come from a
// transaction-level model of the arbitration rules.
module tb_axi_write_arbiter;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW     = DATA_W / 8;
  localparam int unsigned ROUND_BUDGET = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side signals, index = master number
  logic [ID_W-1:0]   m_awid    [2];
  logic [ADDR_W-1:0] m_awaddr  [2];
  logic [7:0]        m_awlen   [2];
  logic [2:0]        m_awsize  [2];
  logic [1:0]        m_awburst [2];
  logic [1:0]        m_awlock  [2];
  logic [3:0]        m_awcache [2];
  logic [2:0]        m_awprot  [2];
  logic              m_awvalid [2];
  logic              m_awready [2];
  logic [ID_W-1:0]   m_wid     [2];
  logic [DATA_W-1:0] m_wdata   [2];
  logic [SW-1:0]     m_wstrb   [2];
  logic              m_wlast   [2];
  logic              m_wvalid  [2];
  logic              m_wready  [2];
  logic [ID_W-1:0]   m_bid     [2];
  logic [1:0]        m_bresp   [2];
  logic              m_bvalid  [2];
  logic              m_bready  [2];

  // slave-side signals
  logic [ID_W-1:0]   s_awid;
  logic [ADDR_W-1:0] s_awaddr;
  logic [7:0]        s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst;
  logic [1:0]        s_awlock;
  logic [3:0]        s_awcache;
  logic [2:0]        s_awprot;
  logic              s_awvalid, s_awready;
  logic [ID_W-1:0]   s_wid;
  logic [DATA_W-1:0] s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_wlast, s_wvalid, s_wready;
  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              s_bvalid, s_bready;
  logic              wr_busy, wr_err;

  axi_write_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_awid    (m_awid[0]),    .m0_awaddr (m_awaddr[0]),  .m0_awlen  (m_awlen[0]),
    .m0_awsize  (m_awsize[0]),  .m0_awburst(m_awburst[0]), .m0_awlock (m_awlock[0]),
    .m0_awcache (m_awcache[0]), .m0_awprot (m_awprot[0]),
    .m0_awvalid (m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wid     (m_wid[0]),     .m0_wdata  (m_wdata[0]),   .m0_wstrb  (m_wstrb[0]),
    .m0_wlast   (m_wlast[0]),   .m0_wvalid (m_wvalid[0]),  .m0_wready (m_wready[0]),
    .m0_bid     (m_bid[0]),     .m0_bresp  (m_bresp[0]),
    .m0_bvalid  (m_bvalid[0]),  .m0_bready (m_bready[0]),
    .m1_awid    (m_awid[1]),    .m1_awaddr (m_awaddr[1]),  .m1_awlen  (m_awlen[1]),
    .m1_awsize  (m_awsize[1]),  .m1_awburst(m_awburst[1]), .m1_awlock (m_awlock[1]),
    .m1_awcache (m_awcache[1]), .m1_awprot (m_awprot[1]),
    .m1_awvalid (m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wid     (m_wid[1]),     .m1_wdata  (m_wdata[1]),   .m1_wstrb  (m_wstrb[1]),
    .m1_wlast   (m_wlast[1]),   .m1_wvalid (m_wvalid[1]),  .m1_wready (m_wready[1]),
    .m1_bid     (m_bid[1]),     .m1_bresp  (m_bresp[1]),
    .m1_bvalid  (m_bvalid[1]),  .m1_bready (m_bready[1]),
    .awid       (s_awid),       .awaddr    (s_awaddr),     .awlen     (s_awlen),
    .awsize     (s_awsize),     .awburst   (s_awburst),    .awlock    (s_awlock),
    .awcache    (s_awcache),    .awprot    (s_awprot),
    .awvalid    (s_awvalid),    .awready   (s_awready),
    .wid        (s_wid),        .wdata     (s_wdata),      .wstrb     (s_wstrb),
    .wlast      (s_wlast),      .wvalid    (s_wvalid),     .wready    (s_wready),
    .bid        (s_bid),        .bresp     (s_bresp),
    .bvalid     (s_bvalid),     .bready    (s_bready),
    .wr_busy    (wr_busy),
    .wr_err     (wr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // master BFM state
  bit                act     [2];
  bit                aw_done [2];
  int unsigned       wsent   [2];
  int unsigned       nb      [2];
  logic [7:0]        len_m   [2];
  logic [ADDR_W-1:0] addr_m  [2];
  logic [ID_W-1:0]   id_m    [2];
  logic [DATA_W-1:0] dbase   [2];

  // transaction-level reference model
  int order [2];
  int n_ord;
  int k;
  bit exp_err;
`ifdef AXI_WR_RR_EN
  bit last_owner;
`endif

  // slave BFM state
  bit                sl_aw_seen;
  bit                sl_wlast_seen;
  int unsigned       sl_beats;
  logic [DATA_W-1:0] sl_sum;
  logic [1:0]        sl_resp;
  logic [ID_W-1:0]   sl_bid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_sum(input logic [DATA_W-1:0] base, input int unsigned n);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int unsigned j = 0; j < n; j++) s += base + DATA_W'(j);
    return s;
  endfunction

  // drive all DUT inputs for the coming cycle (called just after negedge)
  task automatic drive(input bit aw_block);
    for (int unsigned i = 0; i < 2; i++) begin
      m_awvalid[i] = act[i] && !aw_done[i];
      m_awid[i]    = id_m[i];
      m_awaddr[i]  = addr_m[i];
      m_awlen[i]   = len_m[i];
      m_awsize[i]  = 3'd2;
      m_awburst[i] = axi_pkg::BURST_INCR;
      m_awlock[i]  = '0;
      m_awcache[i] = 4'h3;
      m_awprot[i]  = 3'(i);
      m_wvalid[i]  = act[i] && (wsent[i] < nb[i]);
      m_wid[i]     = id_m[i];
      m_wdata[i]   = dbase[i] + DATA_W'(wsent[i]);
      m_wstrb[i]   = '1;
      m_wlast[i]   = (wsent[i] + 1 == nb[i]);
      m_bready[i]  = act[i] && (wsent[i] == nb[i]) && ($urandom_range(0, 3) != 0);
    end
    s_awready = !aw_block && ($urandom_range(0, 2) != 0);
    s_wready  = ($urandom_range(0, 2) != 0);
    s_bvalid  = sl_wlast_seen;
    s_bid     = sl_bid;
    s_bresp   = sl_resp;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_awvalid"}, s_awvalid, 1'b0);
    chk({tag, "_wvalid"},  s_wvalid,  1'b0);
    chk({tag, "_bready"},  s_bready,  1'b0);
    chk({tag, "_busy"},    wr_busy,   1'b0);
    for (int unsigned i = 0; i < 2; i++) begin
      chk({tag, "_m_awready"}, m_awready[i], 1'b0);
      chk({tag, "_m_wready"},  m_wready[i],  1'b0);
      chk({tag, "_m_bvalid"},  m_bvalid[i],  1'b0);
    end
  endtask

  // One round: the selected masters raise AW in the same cycle and each
  // completes one transaction. len < 0 means random length; extra shifts
  // the number of W beats away from len+1 to provoke a length error.
  task automatic run_round(input bit r0, input bit r1, input int l0, input int l1,
                           input int e0, input int e1, input int unsigned aw_hold,
                           input bit do_rst);
    bit          req   [2];
    int          lreq  [2];
    int          extra [2];
    int          tmp;
    int unsigned cyc;
    bit          aborted;
    req[0] = r0;  req[1] = r1;
    lreq[0] = l0; lreq[1] = l1;
    extra[0] = e0; extra[1] = e1;
    for (int unsigned i = 0; i < 2; i++) begin
      if (req[i]) begin
        act[i]     = 1'b1;
        aw_done[i] = 1'b0;
        wsent[i]   = 0;
        len_m[i]   = (lreq[i] < 0) ? 8'($urandom_range(0, 7)) : 8'(lreq[i]);
        tmp        = int'(len_m[i]) + 1 + extra[i];
        nb[i]      = (tmp < 1) ? 1 : tmp;
        addr_m[i]  = ADDR_W'($urandom);
        id_m[i]    = ID_W'($urandom);
        dbase[i]   = DATA_W'($urandom);
        if (nb[i] != int'(len_m[i]) + 1) exp_err = 1'b1;
      end
    end
    n_ord = 0;
    k     = 0;
    if (r0 && r1) begin
`ifdef AXI_WR_RR_EN
      order[0] = last_owner ? 0 : 1;
`else
      order[0] = 0;
`endif
      order[1] = 1 - order[0];
      n_ord    = 2;
    end else if (r0) begin
      order[0] = 0;
      n_ord    = 1;
    end else if (r1) begin
      order[0] = 1;
      n_ord    = 1;
    end
`ifdef AXI_WR_RR_EN
    if (n_ord > 0) last_owner = (order[n_ord-1] == 1);
`endif
    cyc     = 0;
    aborted = 1'b0;
    while (k < n_ord && cyc < ROUND_BUDGET) begin
      int cur;
      @(negedge clk);
      drive(cyc < aw_hold);
      #1;
      cur = order[k];
      for (int unsigned i = 0; i < 2; i++) begin
        if (int'(i) != cur) begin
          chk("nonowner_awready", m_awready[i], 1'b0);
          chk("nonowner_wready",  m_wready[i],  1'b0);
          chk("nonowner_bvalid",  m_bvalid[i],  1'b0);
        end
      end
      if (!sl_aw_seen)    chk("w_before_aw", s_wvalid, 1'b0);
      if (!sl_wlast_seen) chk("bready_outside_resp", s_bready, 1'b0);
      if (s_awvalid && s_awready) begin
        chk("aw_addr",  s_awaddr,  addr_m[cur]);
        chk("aw_id",    s_awid,    id_m[cur]);
        chk("aw_len",   s_awlen,   len_m[cur]);
        chk("aw_burst", s_awburst, axi_pkg::BURST_INCR);
        chk("aw_owner_ready", m_awready[cur], 1'b1);
        sl_aw_seen = 1'b1;
        sl_bid     = s_awid;
        sl_beats   = 0;
        sl_sum     = '0;
        sl_resp    = 2'($urandom_range(0, 3));
      end
      for (int unsigned i = 0; i < 2; i++) begin
        if (m_awvalid[i] && m_awready[i]) aw_done[i] = 1'b1;
        if (m_wvalid[i] && m_wready[i])   wsent[i]++;
      end
      if (s_wvalid && s_wready) begin
        sl_beats++;
        sl_sum += s_wdata;
        if (s_wlast) begin
          sl_wlast_seen = 1'b1;
          chk("w_beats",    sl_beats, nb[cur]);
          chk("w_data_sum", sl_sum,   exp_sum(dbase[cur], nb[cur]));
        end
      end
      if (s_bvalid && s_bready) begin
        chk("b_route", m_bvalid[cur], 1'b1);
        chk("b_resp",  m_bresp[cur],  sl_resp);
        chk("b_id",    m_bid[cur],    sl_bid);
        sl_aw_seen    = 1'b0;
        sl_wlast_seen = 1'b0;
        k++;
      end
      for (int unsigned i = 0; i < 2; i++) begin
        if (m_bvalid[i] && m_bready[i]) act[i] = 1'b0;
      end
      if (do_rst && sl_aw_seen && sl_beats >= 1 && !sl_wlast_seen) begin
        rst = 1'b0;
        #1;
        chk_all_quiet("rst_mid_data");
        chk("rst_mid_data_err", wr_err, 1'b0);
        act[0] = 1'b0;
        act[1] = 1'b0;
        sl_aw_seen    = 1'b0;
        sl_wlast_seen = 1'b0;
        exp_err       = 1'b0;
`ifdef AXI_WR_RR_EN
        last_owner    = 1'b1;
`endif
        k       = n_ord;
        aborted = 1'b1;
      end
      cyc++;
    end
    chk("round_complete", 64'(k), 64'(n_ord));
    act[0] = 1'b0;
    act[1] = 1'b0;
    @(negedge clk);
    drive(1'b0);
    if (aborted) rst = 1'b1;
    #1;
    chk("idle_busy", wr_busy, 1'b0);
    chk("err_flag",  wr_err,  exp_err);
  endtask

  initial begin
    for (int unsigned i = 0; i < 2; i++) begin
      act[i] = 1'b0; aw_done[i] = 1'b0; wsent[i] = 0; nb[i] = 0;
      len_m[i] = '0; addr_m[i] = '0; id_m[i] = '0; dbase[i] = '0;
    end
    sl_aw_seen = 1'b0; sl_wlast_seen = 1'b0; sl_beats = 0;
    sl_sum = '0; sl_resp = '0; sl_bid = '0;
    exp_err = 1'b0;
`ifdef AXI_WR_RR_EN
    last_owner = 1'b1;
`endif
    drive(1'b0);
    #1 rst = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    drive(1'b0);
    #1;
    chk_all_quiet("reset");
    chk("reset_err", wr_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // B response presented while idle is not acknowledged
    for (int unsigned c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b0);
      s_bvalid = 1'b1;
      #1;
      chk("idle_b_bready",  s_bready,    1'b0);
      chk("idle_b_m0valid", m_bvalid[0], 1'b0);
      chk("idle_b_m1valid", m_bvalid[1], 1'b0);
      chk("idle_b_busy",    wr_busy,     1'b0);
    end

    // M0 alone, 4-beat burst
    run_round(1'b1, 1'b0, 3, 0, 0, 0, 0, 1'b0);
    // simultaneous requests
    run_round(1'b1, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run_round(1'b1, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run_round(1'b1, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    // AW stalled for 5 cycles while W is offered early
    run_round(1'b1, 1'b0, 3, 0, 0, 0, 5, 1'b0);
    // short burst: awlen=1 with wlast on the first beat
    run_round(1'b0, 1'b1, 0, 1, 0, -1, 0, 1'b0);
    // error stays set across good traffic
    run_round(1'b1, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run_round(1'b0, 1'b1, 2, -1, 0, 0, 0, 1'b0);

    // randomized rounds, occasionally with too many or too few beats
    for (int unsigned r = 0; r < 16; r++) begin
      bit a, b;
      int ea, eb;
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      if (!a && !b) a = 1'b1;
      ea = ($urandom_range(0, 7) == 0) ? 1 : 0;
      eb = ($urandom_range(0, 7) == 0) ? -1 : 0;
      run_round(a, b, -1, -1, ea, eb, $urandom_range(0, 3), 1'b0);
    end

    // reset during a data phase, then normal arbitration again
    run_round(1'b1, 1'b1, 3, 3, 0, 0, 0, 1'b1);
    run_round(1'b1, 1'b1, -1, -1, 0, 0, 0, 1'b0);
    run_round(1'b0, 1'b1, -1, -1, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
